// File: rtl/xadc_drp_reader.sv
// xadc_drp_reader
//   DRP read initiator for the XADC continuous sequence on vaux4 (current) and
//   vaux12 (voltage). Each end-of-sequence pulse triggers two single-cycle DRP
//   reads, current first and then voltage. Both results are published together
//   as one sample on a valid/ready output. The block never writes DRP registers.
//
// Ports
//   dclk_in             clock for all logic
//   reset_in            synchronous, active-high reset
//   den_out             DRP enable, one-cycle pulse per read
//   dwe_out             DRP write enable, tied low
//   di_out              DRP write data, tied to zero
//   daddr_out           DRP address, non-zero only while den_out is high
//   drdy_in / do_in     DRP read strobe and read data
//   eos_in              XADC end-of-sequence pulse
//   current_sample_out  last captured vaux4 result
//   voltage_sample_out  last captured vaux12 result
//   sample_valid_out    sample pair available
//   sample_ready_in     downstream accepts the sample
//   timeout_out         one-cycle pulse when a DRP read is aborted
//   overrun_count_out   saturating count of dropped EOS events

package xadc_drp_package;
  localparam int XADC_DRP_DATA_WIDTH      = 16;
  localparam int XADC_DRP_AXIS_ADDR_WIDTH = 7;
  // XADC status registers for auxiliary channels live at 0x10 + channel.
  localparam logic [XADC_DRP_AXIS_ADDR_WIDTH-1:0] XADC_DRP_ADDR_CURRENT_CHANNEL = 7'h14;
  localparam logic [XADC_DRP_AXIS_ADDR_WIDTH-1:0] XADC_DRP_ADDR_VOLTAGE_CHANNEL = 7'h1C;
endpackage

module xadc_drp_reader
  import xadc_drp_package::*;
#(
  parameter int INTER_READ_GAP     = 4,
  parameter int DRP_TIMEOUT_CYCLES = 64
) (
  input  logic                                dclk_in,
  input  logic                                reset_in,
  output logic                                den_out,
  output logic                                dwe_out,
  output logic [XADC_DRP_DATA_WIDTH-1:0]      di_out,
  output logic [XADC_DRP_AXIS_ADDR_WIDTH-1:0] daddr_out,
  input  logic                                drdy_in,
  input  logic [XADC_DRP_DATA_WIDTH-1:0]      do_in,
  input  logic                                eos_in,
  output logic [15:0]                         current_sample_out,
  output logic [15:0]                         voltage_sample_out,
  output logic                                sample_valid_out,
  input  logic                                sample_ready_in,
  output logic                                timeout_out,
  output logic [7:0]                          overrun_count_out
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_CURRENT,
    WAIT_CURRENT,
    GAP,
    REQ_VOLTAGE,
    WAIT_VOLTAGE,
    PUBLISH
  } state_t;

  // Terminal counts: the counter is cleared on entry to WAIT_* / GAP, so the
  // last cycle of either phase is the one where it holds N-1.
  localparam logic [7:0] TIMEOUT_LAST = 8'(DRP_TIMEOUT_CYCLES - 1);
  localparam logic [7:0] GAP_LAST     = 8'(INTER_READ_GAP - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic       pending;
  logic       cnt_clear;
  logic       cnt_inc;
  logic       cap_current;
  logic       cap_voltage;
  logic       start;

  assign dwe_out = 1'b0;
  assign di_out  = '0;

  always_ff @(posedge dclk_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next       = state;
    den_out          = 1'b0;
    daddr_out        = '0;
    sample_valid_out = 1'b0;
    timeout_out      = 1'b0;
    cnt_clear        = 1'b0;
    cnt_inc          = 1'b0;
    cap_current      = 1'b0;
    cap_voltage      = 1'b0;
    start            = 1'b0;
    case (state)
      IDLE: begin
        if (eos_in || pending) begin
          start      = 1'b1;
          state_next = REQ_CURRENT;
        end
      end
      REQ_CURRENT: begin
        den_out    = 1'b1;
        daddr_out  = XADC_DRP_ADDR_CURRENT_CHANNEL;
        cnt_clear  = 1'b1;
        state_next = WAIT_CURRENT;
      end
      WAIT_CURRENT: begin
        if (drdy_in) begin
          cap_current = 1'b1;
          cnt_clear   = 1'b1;
          state_next  = GAP;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout_out = 1'b1;
          state_next  = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) state_next = REQ_VOLTAGE;
        else                 cnt_inc    = 1'b1;
      end
      REQ_VOLTAGE: begin
        den_out    = 1'b1;
        daddr_out  = XADC_DRP_ADDR_VOLTAGE_CHANNEL;
        cnt_clear  = 1'b1;
        state_next = WAIT_VOLTAGE;
      end
      WAIT_VOLTAGE: begin
        if (drdy_in) begin
          cap_voltage = 1'b1;
          state_next  = PUBLISH;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout_out = 1'b1;
          state_next  = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      PUBLISH: begin
        sample_valid_out = 1'b1;
        if (sample_ready_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge dclk_in) begin
    if (reset_in) begin
      cnt                <= '0;
      current_sample_out <= '0;
      voltage_sample_out <= '0;
      pending            <= 1'b0;
      overrun_count_out  <= '0;
    end else begin
      if (cnt_clear)    cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 8'd1;

      if (cap_current) current_sample_out <= do_in;
      if (cap_voltage) voltage_sample_out <= do_in;

      // One EOS may wait while busy; any further EOS before it is serviced
      // is dropped and counted. An EOS seen in IDLE is consumed by start.
      if (start) begin
        pending <= 1'b0;
      end else if (eos_in && state != IDLE) begin
        if (!pending)                         pending           <= 1'b1;
        else if (overrun_count_out != 8'hFF)  overrun_count_out <= overrun_count_out + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_xadc_drp_reader.sv
module tb_xadc_drp_reader;

  logic        dclk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        den_out;
  logic        dwe_out;
  logic [15:0] di_out;
  logic [6:0]  daddr_out;
  logic        drdy_in = 1'b0;
  logic [15:0] do_in = '0;
  logic        eos_in = 1'b0;
  logic [15:0] current_sample_out;
  logic [15:0] voltage_sample_out;
  logic        sample_valid_out;
  logic        sample_ready_in = 1'b0;
  logic        timeout_out;
  logic [7:0]  overrun_count_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 dclk_in = ~dclk_in;

  xadc_drp_reader #(
    .INTER_READ_GAP(4),
    .DRP_TIMEOUT_CYCLES(64)
  ) dut (
    .dclk_in(dclk_in),
    .reset_in(reset_in),
    .den_out(den_out),
    .dwe_out(dwe_out),
    .di_out(di_out),
    .daddr_out(daddr_out),
    .drdy_in(drdy_in),
    .do_in(do_in),
    .eos_in(eos_in),
    .current_sample_out(current_sample_out),
    .voltage_sample_out(voltage_sample_out),
    .sample_valid_out(sample_valid_out),
    .sample_ready_in(sample_ready_in),
    .timeout_out(timeout_out),
    .overrun_count_out(overrun_count_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge dclk_in);
    #1;
  endtask

  task automatic pulse_eos();
    eos_in = 1'b1;
    step();
    eos_in = 1'b0;
  endtask

  task automatic respond_read(input logic [6:0] addr, input logic [15:0] data,
                              input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (den_out) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check({tag, "_den_seen"}, seen, 1'b1);
    check({tag, "_addr"}, daddr_out, addr);
    step();
    step();
    step();
    drdy_in = 1'b1;
    do_in   = data;
    step();
    drdy_in = 1'b0;
    do_in   = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_den"}, den_out, 1'b0);
    check({tag, "_dwe"}, dwe_out, 1'b0);
    check({tag, "_di"}, di_out, 16'h0000);
    check({tag, "_daddr"}, daddr_out, 7'h00);
    check({tag, "_cur"}, current_sample_out, 16'h0000);
    check({tag, "_volt"}, voltage_sample_out, 16'h0000);
    check({tag, "_valid"}, sample_valid_out, 1'b0);
    check({tag, "_timeout"}, timeout_out, 1'b0);
    check({tag, "_ovr"}, overrun_count_out, 8'd0);
  endtask

  initial begin
    step();
    step();
    step();
    check_reset_values("reset");
    reset_in = 1'b0;
    step();

    sample_ready_in = 1'b1;
    pulse_eos();
    check("eos_den", den_out, 1'b1);
    check("eos_addr", daddr_out, 7'h14);
    step();
    check("den_one_cycle", den_out, 1'b0);
    check("addr_idle", daddr_out, 7'h00);
    step();
    step();
    drdy_in = 1'b1;
    do_in   = 16'h1230;
    step();
    drdy_in = 1'b0;
    do_in   = '0;
    check("cur_capture", current_sample_out, 16'h1230);
    step();
    step();
    step();
    check("gap_no_den", den_out, 1'b0);
    step();
    check("volt_den", den_out, 1'b1);
    check("volt_addr", daddr_out, 7'h1C);
    step();
    step();
    step();
    check("no_valid_early", sample_valid_out, 1'b0);
    drdy_in = 1'b1;
    do_in   = 16'h4560;
    step();
    drdy_in = 1'b0;
    do_in   = '0;
    check("valid_rise", sample_valid_out, 1'b1);
    check("pub_cur", current_sample_out, 16'h1230);
    check("pub_volt", voltage_sample_out, 16'h4560);
    step();
    check("accepted", sample_valid_out, 1'b0);
    step();
    check("idle_no_den", den_out, 1'b0);

    sample_ready_in = 1'b0;
    pulse_eos();
    respond_read(7'h14, 16'hAAAA, "stall_cur");
    respond_read(7'h1C, 16'h5555, "stall_volt");
    check("stall_valid", sample_valid_out, 1'b1);
    for (int c = 0; c < 50; c++) begin
      eos_in = (c == 10 || c == 20 || c == 30);
      step();
      eos_in = 1'b0;
      check("hold_valid", sample_valid_out, 1'b1);
      check("hold_cur", current_sample_out, 16'hAAAA);
      check("hold_volt", voltage_sample_out, 16'h5555);
      check("hold_den", den_out, 1'b0);
    end
    check("stall_ovr", overrun_count_out, 8'd2);
    sample_ready_in = 1'b1;
    step();
    check("release_valid", sample_valid_out, 1'b0);
    check("release_idle_den", den_out, 1'b0);
    step();
    check("pending_den", den_out, 1'b1);
    check("pending_addr", daddr_out, 7'h14);
    respond_read(7'h14, 16'h0111, "pend_cur");
    respond_read(7'h1C, 16'h0222, "pend_volt");
    check("pend_valid", sample_valid_out, 1'b1);
    check("pend_cur_val", current_sample_out, 16'h0111);
    check("pend_volt_val", voltage_sample_out, 16'h0222);
    step();
    begin
      bit extra_den = 1'b0;
      for (int c = 0; c < 20; c++) begin
        step();
        if (den_out) extra_den = 1'b1;
      end
      check("single_sequence", extra_den, 1'b0);
    end
    check("pend_ovr_kept", overrun_count_out, 8'd2);

    pulse_eos();
    check("to_den", den_out, 1'b1);
    for (int c = 1; c < 64; c++) begin
      step();
      check("to_quiet", timeout_out, 1'b0);
    end
    step();
    check("to_pulse", timeout_out, 1'b1);
    check("to_no_valid", sample_valid_out, 1'b0);
    step();
    check("to_pulse_end", timeout_out, 1'b0);
    check("to_idle_den", den_out, 1'b0);
    check("to_cur_kept", current_sample_out, 16'h0111);
    step();
    check("to_still_idle", den_out, 1'b0);

    pulse_eos();
    check("fresh_den", den_out, 1'b1);
    check("fresh_addr", daddr_out, 7'h14);
    respond_read(7'h14, 16'h0BEE, "partial_cur");
    respond_read(7'h1C, 16'h0000, "partial_dummy_never");
    check("partial_valid", sample_valid_out, 1'b1);
    step();
    pulse_eos();
    respond_read(7'h14, 16'h0C0C, "vto_cur");
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (den_out) begin
          seen = 1'b1;
          break;
        end
        step();
      end
      check("vto_den_seen", seen, 1'b1);
      check("vto_addr", daddr_out, 7'h1C);
    end
    for (int c = 1; c < 64; c++) step();
    step();
    check("vto_pulse", timeout_out, 1'b1);
    step();
    check("vto_no_valid", sample_valid_out, 1'b0);
    check("vto_cur_partial", current_sample_out, 16'h0C0C);
    check("vto_volt_kept", voltage_sample_out, 16'h0000);

    pulse_eos();
    respond_read(7'h14, 16'h7777, "rst_cur");
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (den_out) begin
          seen = 1'b1;
          break;
        end
        step();
      end
      check("rst_vden_seen", seen, 1'b1);
    end
    step();
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    drdy_in  = 1'b1;
    do_in    = 16'h9999;
    step();
    drdy_in = 1'b0;
    do_in   = '0;
    check_reset_values("midrst");
    step();
    step();
    check("midrst_no_valid", sample_valid_out, 1'b0);
    check("midrst_no_capture", voltage_sample_out, 16'h0000);

    sample_ready_in = 1'b0;
    pulse_eos();
    respond_read(7'h14, 16'h0001, "sat_cur");
    respond_read(7'h1C, 16'h0002, "sat_volt");
    check("sat_valid", sample_valid_out, 1'b1);
    for (int p = 1; p <= 300; p++) begin
      pulse_eos();
      step();
      if (p == 255) check("ovr_254", overrun_count_out, 8'd254);
      if (p == 256) check("ovr_255", overrun_count_out, 8'd255);
    end
    check("ovr_saturated", overrun_count_out, 8'd255);
    check("sat_held_valid", sample_valid_out, 1'b1);
    check("sat_held_volt", voltage_sample_out, 16'h0002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares != 0) $error("FAIL: %0d miscompares", miscompares);
    $finish;
  end

endmodule

// File: doc/xadc_drp_reader.md
# xadc_drp_reader

DRP initiator for the CMOD A7 35T XADC running a continuous sequence on channels vaux4 (current) and vaux12 (voltage). On each end-of-sequence pulse it issues two single-cycle DRP reads, current first, then voltage. It captures both 16-bit results and presents them together as one sample on a valid/ready output. It sits between the XADC wizard instance (or xadc_bfm in simulation) and the downstream sample pipeline. It is read-only and never writes DRP registers.

## Interface
Parameters:
- INTER_READ_GAP, default 4: idle cycles between the current-read drdy and the voltage-read den; legal range 1..15.
- DRP_TIMEOUT_CYCLES, default 64: cycles to wait for drdy after den before aborting; legal range 2..255.

Ports:
- dclk_in  input  1  clock; drives all logic.
- reset_in  input  1  reset; synchronous, active-high.
- den_out  output  1  DRP enable; one-cycle pulse per read.
- dwe_out  output  1  DRP write enable; constant 0.
- di_out  output  XADC_DRP_DATA_WIDTH  DRP write data; constant 0.
- daddr_out  output  XADC_DRP_AXIS_ADDR_WIDTH  DRP address; valid while den_out is high.
- drdy_in  input  1  DRP read data valid.
- do_in  input  XADC_DRP_DATA_WIDTH  DRP read data.
- eos_in  input  1  XADC end-of-sequence pulse.
- current_sample_out  output  16  raw vaux4 result.
- voltage_sample_out  output  16  raw vaux12 result.
- sample_valid_out  output  1  sample pair available.
- sample_ready_in  input  1  downstream accepts the sample.
- timeout_out  output  1  one-cycle pulse when a DRP read is aborted.
- overrun_count_out  output  8  saturating count of dropped EOS events.

The address constants and widths come from xadc_drp_package.

## Operation
- State machine states: IDLE, REQ_CURRENT, WAIT_CURRENT, GAP, REQ_VOLTAGE, WAIT_VOLTAGE, PUBLISH.
- IDLE
  - If eos_in or the pending flag is set, go to REQ_CURRENT and clear pending.
- REQ_CURRENT
  - den_out=1 and daddr_out=XADC_DRP_ADDR_CURRENT_CHANNEL for this cycle only.
  - Go to WAIT_CURRENT and clear the timeout counter.
- WAIT_CURRENT
  - On drdy_in=1: load do_in into current_sample_out, then go to GAP.
  - Otherwise increment the counter. When it reaches DRP_TIMEOUT_CYCLES, pulse timeout_out and go to IDLE.
- GAP
  - Count INTER_READ_GAP cycles, then go to REQ_VOLTAGE.
- REQ_VOLTAGE
  - Same as REQ_CURRENT, using XADC_DRP_ADDR_VOLTAGE_CHANNEL.
- WAIT_VOLTAGE
  - On drdy_in=1: load do_in into voltage_sample_out, then go to PUBLISH.
  - Timeout behaves as in WAIT_CURRENT.
- PUBLISH
  - sample_valid_out=1.
  - When sample_valid_out and sample_ready_in are both high at a clock edge, go to IDLE.
- EOS outside IDLE:
  - If pending=0, set pending=1.
  - If pending is already 1, increment overrun_count_out, saturating at 255.
  - An eos_in in IDLE starts immediately and is never counted.
- drdy_in outside WAIT_* is ignored.
- Aborted sequences do not publish. The sample registers keep their last successfully captured values; a partial capture may update current_sample_out only.
- den_out is never high in two consecutive cycles. daddr_out returns to 0 when den_out is low.

## Timing
- Reset values: den_out=0, dwe_out=0, di_out=0, daddr_out=0, current_sample_out=0, voltage_sample_out=0, sample_valid_out=0, timeout_out=0, overrun_count_out=0, pending=0, state=IDLE.
- Reset mid-sequence returns to IDLE at the next edge with all the values above. Any outstanding drdy is then ignored.
- eos_in high at edge N in IDLE → den_out high during cycle N+1.
- drdy_in sampled high at edge M in WAIT_CURRENT → current_sample_out updates at M. Voltage den_out is high during cycle M+INTER_READ_GAP+1.
- Voltage drdy sampled at edge K → voltage_sample_out updates at K and sample_valid_out is high from cycle K+1.
- With ready held high, the sample is accepted one cycle after valid rises and the FSM is in IDLE on the following cycle.
- Timeout: if drdy never arrives, timeout_out pulses DRP_TIMEOUT_CYCLES cycles after the den cycle.
- Outputs stay stable while sample_valid_out=1 and sample_ready_in=0.
- Default gap of 4 is required with xadc_bfm, which accepts den only 3 cycles after its drdy.

## Test plan
- Against xadc_bfm after reset, ready=1 → first sample has current_sample_out=0x0F7F and voltage_sample_out=0x0FFF.
  - den_out pulses exactly twice per sample, with daddr current then voltage.
  - Samples repeat continuously and overrun_count_out stays 0.
- Hand-driven DRP with drdy 3 cycles after each den → valid rises on the cycle after the second drdy with both captured values, e.g. 0x1230 and 0x4560.
- Hold sample_ready_in=0 for 50 cycles while eos_in pulses 3 times → sample held stable, pending=1, overrun_count_out=2.
  - After ready rises, one new sequence starts from IDLE.
- Never assert drdy_in → timeout_out pulses 64 cycles after den and the FSM returns to IDLE.
  - No sample_valid_out, and the next eos_in starts a fresh read.
- Assert reset_in during WAIT_VOLTAGE, then drive a late drdy_in → all outputs at reset values and no capture.
- Pulse eos_in 300 times during a stalled PUBLISH → overrun_count_out saturates at 255.
